// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control path:
// opcodes, controller states and ALU B-operand select encodings.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALUB_REG  = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_R_EXEC,
    ST_R_WB,
    ST_BRANCH,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_branch;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic [1:0] alu_src_b;
  } ctrl_en_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> datapath-enable decoder for the multi-cycle controller.
// Only ir_write/pc_write (on mem_ready) and pc_branch (on zero) depend on inputs.
module mc_ctrl_outdec
  import cpu_pkg::*;
(
  input  state_t   state,
  input  logic     mem_ready,
  input  logic     zero,
  output ctrl_en_t en
);

  always_comb begin
    en = '0;
    case (state)
      ST_FETCH: begin
        en.mem_read  = 1'b1;
        en.alu_src_b = ALUB_FOUR;
        en.ir_write  = mem_ready;
        en.pc_write  = mem_ready;
      end
      ST_DECODE:   en.alu_src_b = ALUB_IMM;
      ST_MEM_ADDR: en.alu_src_b = ALUB_IMM;
      ST_MEM_RD: begin
        en.mem_read = 1'b1;
        en.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        en.reg_write  = 1'b1;
        en.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        en.mem_write = 1'b1;
        en.i_or_d    = 1'b1;
      end
      ST_R_EXEC:   en.alu_src_b = ALUB_REG;
      ST_R_WB: begin
        en.reg_write = 1'b1;
        en.reg_dst   = 1'b1;
      end
      ST_BRANCH:   en.pc_branch = zero;
      default:     en = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main control unit: sequences fetch/decode/execute, latches the
// instruction class strobes, flags illegal opcodes and counts retirements.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   FETCH       | read instruction at PC, load IR and PC+4 on ready
//   DECODE      | classify opcode, precompute branch target
//   MEM_ADDR    | compute lw/sw effective address
//   MEM_RD      | data read, wait for ready
//   MEM_WB      | write loaded word to rt, retire
//   MEM_WR      | data write, wait for ready, retire
//   R_EXEC      | ALU operation on register operands
//   R_WB        | write ALU result to rd, retire
//   BRANCH      | compare, take branch when zero, retire
//   HALT        | illegal opcode seen, wait for reset
module mc_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             lw,
  output logic             sw,
  output logic             beq,
  output logic             rtype,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic [1:0]       alu_src_b,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t   state;
  ctrl_en_t en;
  logic     retire;

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .en        (en)
  );

  assign ir_write   = en.ir_write;
  assign pc_write   = en.pc_write;
  assign pc_branch  = en.pc_branch;
  assign mem_read   = en.mem_read;
  assign mem_write  = en.mem_write;
  assign i_or_d     = en.i_or_d;
  assign reg_write  = en.reg_write;
  assign mem_to_reg = en.mem_to_reg;
  assign reg_dst    = en.reg_dst;
  assign alu_src_b  = en.alu_src_b;

  always_comb begin
    retire = 1'b0;
    case (state)
      ST_MEM_WB, ST_R_WB, ST_BRANCH: retire = 1'b1;
      ST_MEM_WR:                     retire = mem_ready;
      default:                       retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      lw      <= 1'b0;
      sw      <= 1'b0;
      beq     <= 1'b0;
      rtype   <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        ST_FETCH:    if (mem_ready) state <= ST_DECODE;
        ST_DECODE: begin
          lw    <= 1'b0;
          sw    <= 1'b0;
          beq   <= 1'b0;
          rtype <= 1'b0;
          case (opcode)
            OP_LW:    begin lw    <= 1'b1; state <= ST_MEM_ADDR; end
            OP_SW:    begin sw    <= 1'b1; state <= ST_MEM_ADDR; end
            OP_RTYPE: begin rtype <= 1'b1; state <= ST_R_EXEC;   end
            OP_BEQ:   begin beq   <= 1'b1; state <= ST_BRANCH;   end
            default:  begin illegal <= 1'b1; state <= ST_HALT;  end
          endcase
        end
        ST_MEM_ADDR: state <= lw ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD:   if (mem_ready) state <= ST_MEM_WB;
        ST_R_EXEC:   state <= ST_R_WB;
        ST_HALT:     state <= ST_HALT;
        default:     state <= state;
      endcase
      // Every retiring state returns to FETCH with the strobes dropped.
      if (retire) begin
        state   <= ST_FETCH;
        lw      <= 1'b0;
        sw      <= 1'b0;
        beq     <= 1'b0;
        rtype   <= 1'b0;
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Cycle-by-cycle vector bench for mc_ctrl_fsm: each row holds the inputs for
// one cycle and the state the controller is expected to be in during it.
module tb_mc_ctrl_fsm;

  localparam int CW = 4;
  localparam logic [5:0] T_RT  = 6'b000000;
  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_SW  = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100;
  localparam logic [5:0] T_BAD = 6'b111111;

  localparam logic [3:0] S0   = 4'b0000;
  localparam logic [3:0] SLW  = 4'b1000;
  localparam logic [3:0] SSW  = 4'b0100;
  localparam logic [3:0] SBEQ = 4'b0010;
  localparam logic [3:0] SRT  = 4'b0001;

  typedef enum int {S_F, S_D, S_MA, S_MR, S_MB, S_MW, S_RE, S_RW, S_BR, S_H} st_e;

  typedef struct {
    logic          rst;
    logic [5:0]    op;
    logic          rdy;
    logic          z;
    st_e           st;
    logic [3:0]    str;
    logic          ill;
    logic [CW-1:0] ret;
    logic          chk;
  } vec_t;

  logic clk = 1'b0;
  logic rst, mem_ready, zero;
  logic [5:0] opcode;
  logic lw, sw, beq, rtype, ir_write, pc_write, pc_branch, mem_read, mem_write;
  logic i_or_d, reg_write, mem_to_reg, reg_dst, illegal;
  logic [1:0] alu_src_b;
  logic [CW-1:0] retired;

  vec_t vecs[200];
  int   nvec = 0;
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .lw(lw), .sw(sw), .beq(beq), .rtype(rtype),
    .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_b(alu_src_b), .illegal(illegal), .retired(retired)
  );

  // {ir_write, pc_write, pc_branch, mem_read, mem_write, i_or_d,
  //  reg_write, mem_to_reg, reg_dst, alu_src_b}
  function automatic logic [10:0] exp_en(input st_e s, input logic rdy, input logic z);
    logic [10:0] e;
    e = '0;
    case (s)
      S_F:  e = {rdy, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
      S_D:  e[1:0] = 2'b10;
      S_MA: e[1:0] = 2'b10;
      S_MR: e = 11'b000_101_000_00;
      S_MB: e = 11'b000_000_110_00;
      S_MW: e = 11'b000_011_000_00;
      S_RW: e = 11'b000_000_101_00;
      S_BR: e[8] = z;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic rdy, input logic z,
                     input st_e s, input logic [3:0] str, input logic ill, input int ret,
                     input logic chk);
    vecs[nvec] = '{r, o, rdy, z, s, str, ill, CW'(ret), chk};
    nvec++;
  endtask

  task automatic fill();
    add(1, T_RT, 0, 0, S_F, S0, 0, 0, 0);
    // lw, ready always high
    add(0, T_BAD, 1, 0, S_F,  S0,  0, 0, 1);
    add(0, T_LW,  1, 0, S_D,  S0,  0, 0, 1);
    add(0, T_BAD, 1, 0, S_MA, SLW, 0, 0, 1);
    add(0, T_BAD, 1, 0, S_MR, SLW, 0, 0, 1);
    add(0, T_BAD, 1, 0, S_MB, SLW, 0, 0, 1);
    // sw with three wait cycles; ready ignored in DECODE/MEM_ADDR
    add(0, T_BAD, 1, 0, S_F,  S0,  0, 1, 1);
    add(0, T_SW,  0, 0, S_D,  S0,  0, 1, 1);
    add(0, T_BAD, 0, 0, S_MA, SSW, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(0, T_BAD, 0, 0, S_MW, SSW, 0, 1, 1);
    add(0, T_BAD, 1, 0, S_MW, SSW, 0, 1, 1);
    // beq taken then not taken
    add(0, T_BAD, 1, 0, S_F,  S0,   0, 2, 1);
    add(0, T_BEQ, 1, 0, S_D,  S0,   0, 2, 1);
    add(0, T_BAD, 1, 1, S_BR, SBEQ, 0, 2, 1);
    add(0, T_BAD, 1, 0, S_F,  S0,   0, 3, 1);
    add(0, T_BEQ, 1, 0, S_D,  S0,   0, 3, 1);
    add(0, T_BAD, 1, 0, S_BR, SBEQ, 0, 3, 1);
    // FETCH stall, then R-type
    add(0, T_BAD, 0, 0, S_F,  S0,  0, 4, 1);
    add(0, T_BAD, 1, 0, S_F,  S0,  0, 4, 1);
    add(0, T_RT,  1, 0, S_D,  S0,  0, 4, 1);
    add(0, T_BAD, 1, 1, S_RE, SRT, 0, 4, 1);
    add(0, T_BAD, 1, 1, S_RW, SRT, 0, 4, 1);
    // illegal opcode -> HALT for 10 cycles, then reset
    add(0, T_BAD, 1, 0, S_F,  S0,  0, 5, 1);
    add(0, T_BAD, 1, 0, S_D,  S0,  0, 5, 1);
    for (int i = 0; i < 10; i++) add(0, T_LW, i[0], 1, S_H, S0, 1, 5, 1);
    add(1, T_LW,  1, 1, S_H,  S0,  1, 5, 1);
    // reset during a stalled store
    add(0, T_BAD, 1, 0, S_F,  S0,  0, 0, 1);
    add(0, T_SW,  1, 0, S_D,  S0,  0, 0, 1);
    add(0, T_BAD, 1, 0, S_MA, SSW, 0, 0, 1);
    add(0, T_BAD, 0, 0, S_MW, SSW, 0, 0, 1);
    add(1, T_BAD, 0, 0, S_MW, SSW, 0, 0, 1);
    add(0, T_BAD, 0, 0, S_F,  S0,  0, 0, 1);
    // 16 R-types: counter wraps 15 -> 0
    for (int k = 0; k < 16; k++) begin
      add(0, T_BAD, 1, 0, S_F,  S0,  0, k, 1);
      add(0, T_RT,  1, 0, S_D,  S0,  0, k, 1);
      add(0, T_BAD, 1, 1, S_RE, SRT, 0, k, 1);
      add(0, T_BAD, 1, 1, S_RW, SRT, 0, k, 1);
    end
    add(0, T_BAD, 1, 0, S_F,  S0,  0, 16, 1);
  endtask

  always @(negedge clk) begin
    vec_t v;
    logic [10:0] act_en, want_en;
    if (sb.size() > 0) begin
      v = sb.pop_front();
      if (v.chk) begin
        act_en  = {ir_write, pc_write, pc_branch, mem_read, mem_write, i_or_d,
                   reg_write, mem_to_reg, reg_dst, alu_src_b};
        want_en = exp_en(v.st, v.rdy, v.z);
        checks++;
        if (act_en !== want_en) begin
          errors++;
          $display("FAIL enables t=%0t state=%s got %b want %b", $time, v.st.name(), act_en, want_en);
        end
        checks++;
        if ({lw, sw, beq, rtype} !== v.str) begin
          errors++;
          $display("FAIL strobes t=%0t state=%s got %b want %b", $time, v.st.name(), {lw, sw, beq, rtype}, v.str);
        end
        checks++;
        if (illegal !== v.ill) begin
          errors++;
          $display("FAIL illegal t=%0t got %b want %b", $time, illegal, v.ill);
        end
        checks++;
        if (retired !== v.ret) begin
          errors++;
          $display("FAIL retired t=%0t got %0d want %0d", $time, retired, v.ret);
        end
        checks++;
        if (mem_read && mem_write) begin
          errors++;
          $display("FAIL mem_excl t=%0t got rd=%b wr=%b want not both", $time, mem_read, mem_write);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    opcode = T_RT;
    mem_ready = 1'b0;
    zero = 1'b0;
    fill();
    for (int i = 0; i < nvec; i++) begin
      @(posedge clk);
      #1;
      rst       = vecs[i].rst;
      opcode    = vecs[i].op;
      mem_ready = vecs[i].rdy;
      zero      = vecs[i].z;
      sb.push_back(vecs[i]);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
